if_fetch_unit: RTL and testbench

Instruction-fetch bus master directly upstream of the IF stage. It takes the combinational fetch PC (`pcF`) and `pcEnable`, and returns the 32-bit instruction on `instF`. It raises `fetch_stall` until that instruction is available, and the stall is ORed into `stallF`. It keeps a one-entry, 64-bit fetch buffer and fills it through a single-outstanding AXI4 read channel on the 64-bit ysyxSoC bus.

---
 rtl/if_fetch_unit.sv | 115 +++++++++++
 tb/tb_if_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch bus master: one-entry 64-bit fetch buffer in front of
// the IF stage, refilled through a single-outstanding AXI4 read channel.
module if_fetch_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       pcF,
    input  logic              pcEnable,
    input  logic              fence_i,
    output logic [31:0]       instF,
    output logic              inst_fault,
    output logic              fetch_stall,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    output logic [2:0]        ar_size,
    output logic [1:0]        ar_burst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [63:0]       r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              buf_valid;
    logic              buf_fault;
    logic [ADDR_W-4:0] buf_tag;
    logic [63:0]       buf_data;
    logic              discard;
    logic              hit;
    logic              fill;
    logic              unused_bits;

    assign ar_len   = 8'd0;
    assign ar_size  = 3'b011;
    assign ar_burst = 2'b01;

    assign unused_bits = ^{pcF[63:ADDR_W], pcF[1:0]};

    assign hit         = buf_valid && (buf_tag == pcF[ADDR_W-1:3]);
    assign fill        = (state == DATA) && r_valid && r_last;
    assign fetch_stall = pcEnable && !hit;
    assign inst_fault  = hit && buf_fault;
    assign instF       = (hit && !buf_fault) ? (pcF[2] ? buf_data[63:32] : buf_data[31:0])
                                             : RESET_NOP;

    // State register; async reset drops ar_valid/r_ready immediately since
    // both are decoded from the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and bus handshake outputs.
    always_comb begin
        state_nxt = state;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        case (state)
            IDLE: if (pcEnable && !hit) state_nxt = ADDR;
            ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = DATA;
            end
            DATA: begin
                r_ready = 1'b1;
                if (r_valid && r_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request address latch: captured only when IDLE launches a miss, so it
    // stays stable through ADDR regardless of pcF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_addr <= '0;
        end else if (state == IDLE && pcEnable && !hit) begin
            ar_addr <= {pcF[ADDR_W-1:3], 3'b000};
        end
    end

    // Fetch buffer fill and invalidation; a fence coincident with the final
    // beat still writes the data but leaves the entry invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_fault <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            discard   <= 1'b0;
        end else if (fill) begin
            buf_tag   <= ar_addr[ADDR_W-1:3];
            buf_data  <= r_data;
            buf_fault <= (r_resp != 2'b00);
            buf_valid <= !discard && !fence_i;
            discard   <= 1'b0;
        end else if (fence_i) begin
            buf_valid <= 1'b0;
            if (state == DATA) discard <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: the bench plays the AXI slave.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [63:0] pcF;
    logic        pcEnable;
    logic        fence_i;
    logic [31:0] instF;
    logic        inst_fault;
    logic        fetch_stall;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_unit #(.ADDR_W(32), .RESET_NOP(32'h0000_0013)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcF        (pcF),
        .pcEnable   (pcEnable),
        .fence_i    (fence_i),
        .instF      (instF),
        .inst_fault (inst_fault),
        .fetch_stall(fetch_stall),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .ar_size    (ar_size),
        .ar_burst   (ar_burst),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .r_last     (r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        r_data   = '0;
        r_resp   = 2'b00;
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        pcEnable = 1'b0;
        fence_i  = 1'b0;
        idle_bus();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
    endtask

    // Slave responder: serves the current miss until fetch_stall drops.
    // Reports stall cycles and AR handshakes; timeout leaves stalls at 50.
    task automatic serve(input logic [63:0] data, input logic [1:0] resp,
                         input int ar_wait, input int r_wait,
                         output int stalls, output int ar_hs);
        int aw;
        int rw;
        aw = 0; rw = 0; stalls = 0; ar_hs = 0;
        for (int c = 0; c < 50; c++) begin
            idle_bus();
            #1;
            if (!fetch_stall) break;
            stalls++;
            if (ar_valid) begin
                if (aw >= ar_wait) ar_ready = 1'b1;
                else aw++;
            end
            if (r_ready) begin
                if (rw >= r_wait) begin
                    r_valid = 1'b1; r_last = 1'b1; r_data = data; r_resp = resp;
                end else rw++;
            end
            #1;
            if (ar_valid && ar_ready) begin ar_hs++; aw = 0; end
            if (r_valid && r_ready) rw = 0;
            next_cycle();
        end
        idle_bus();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pcEnable = 1'b0; fence_i = 1'b0;
        pcF = 64'h0000_0000_8000_0000;
        idle_bus();
        next_cycle();
        next_cycle();
        n_cmp++; if (ar_valid !== 1'b0) begin n_err++; $display("FAIL reset_ar_valid: got %b want 0", ar_valid); end
        n_cmp++; if (r_ready !== 1'b0) begin n_err++; $display("FAIL reset_r_ready: got %b want 0", r_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", fetch_stall); end
        n_cmp++; if (instF !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instF: got %h want 00000013", instF); end
        n_cmp++; if (inst_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", inst_fault); end
        next_cycle();
        pcEnable = 1'b1;
        #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL reset_first_stall: got %b want 1", fetch_stall); end
        n_cmp++; if (ar_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_ar: got %b want 0", ar_valid); end
        next_cycle();
        n_cmp++; if (ar_valid !== 1'b1) begin n_err++; $display("FAIL reset_ar_issue: got %b want 1", ar_valid); end
        n_cmp++; if (ar_addr !== 32'h8000_0000) begin n_err++; $display("FAIL reset_ar_addr: got %h want 80000000", ar_addr); end
        n_cmp++; if ({ar_len, ar_size, ar_burst} !== {8'd0, 3'b011, 2'b01}) begin
            n_err++; $display("FAIL ar_const: got %h/%b/%b want 00/011/01", ar_len, ar_size, ar_burst);
        end
    endtask

    task automatic test_miss_hit();
        int stalls;
        int hs;
        apply_reset();
        pcF = 64'h0000_0000_8000_0000;
        pcEnable = 1'b1;
        serve(64'h00A0_0093_0050_0113, 2'b00, 0, 0, stalls, hs);
        n_cmp++; if (stalls !== 3) begin n_err++; $display("FAIL miss_penalty: got %0d want 3", stalls); end
        n_cmp++; if (hs !== 1) begin n_err++; $display("FAIL miss_ar_count: got %0d want 1", hs); end
        n_cmp++; if (instF !== 32'h0050_0113) begin n_err++; $display("FAIL miss_instF: got %h want 00500113", instF); end
        next_cycle();
        pcF = 64'h0000_0000_8000_0004;
        #1;
        n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL seq_stall: got %b want 0", fetch_stall); end
        n_cmp++; if (instF !== 32'h00A0_0093) begin n_err++; $display("FAIL seq_instF: got %h want 00a00093", instF); end
        next_cycle();
        n_cmp++; if (ar_valid !== 1'b0) begin n_err++; $display("FAIL seq_no_bus: got %b want 0", ar_valid); end
    endtask

    task automatic test_jump_addr();
        int stalls;
        int hs;
        pcF = 64'h0000_0000_8000_0008;
        idle_bus();
        #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL jump_miss: got %b want 1", fetch_stall); end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) pcF = 64'h0000_0000_8000_1000;
            #1;
            n_cmp++; if (ar_valid !== 1'b1 || ar_addr !== 32'h8000_0008) begin
                n_err++; $display("FAIL jump_hold_%0d: got valid=%b addr=%h want 1/80000008", i, ar_valid, ar_addr);
            end
            next_cycle();
        end
        ar_ready = 1'b1;
        next_cycle();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_last = 1'b1; r_data = 64'h1111_2222_3333_4444;
        #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL jump_data_stall: got %b want 1", fetch_stall); end
        next_cycle();
        idle_bus();
        #1;
        n_cmp++; if (fetch_stall !== 1'b1 || ar_valid !== 1'b0) begin
            n_err++; $display("FAIL jump_after_fill: got stall=%b ar_valid=%b want 1/0", fetch_stall, ar_valid);
        end
        serve(64'h5555_6666_7777_8888, 2'b00, 0, 0, stalls, hs);
        n_cmp++; if (stalls !== 3 || hs !== 1) begin n_err++; $display("FAIL jump_refetch: got stalls=%0d hs=%0d want 3/1", stalls, hs); end
        n_cmp++; if (ar_addr !== 32'h8000_1000) begin n_err++; $display("FAIL jump_new_addr: got %h want 80001000", ar_addr); end
        n_cmp++; if (instF !== 32'h7777_8888) begin n_err++; $display("FAIL jump_instF: got %h want 77778888", instF); end
    endtask

    task automatic test_bus_error();
        int stalls;
        int hs;
        pcF = 64'h0000_0000_8000_0010;
        serve(64'hDEAD_BEEF_CAFE_F00D, 2'b10, 1, 1, stalls, hs);
        n_cmp++; if (stalls !== 5) begin n_err++; $display("FAIL err_penalty: got %0d want 5", stalls); end
        n_cmp++; if (inst_fault !== 1'b1 || instF !== 32'h0000_0013) begin
            n_err++; $display("FAIL err_lo: got fault=%b inst=%h want 1/00000013", inst_fault, instF);
        end
        pcF = 64'h0000_0000_8000_0014;
        #1;
        n_cmp++; if (inst_fault !== 1'b1 || instF !== 32'h0000_0013 || fetch_stall !== 1'b0) begin
            n_err++; $display("FAIL err_hi: got fault=%b inst=%h stall=%b want 1/00000013/0", inst_fault, instF, fetch_stall);
        end
        next_cycle();
    endtask

    task automatic test_fence_data();
        int stalls;
        int hs;
        int total;
        total = 0;
        pcF = 64'h0000_0000_8000_0020;
        idle_bus();
        next_cycle();
        ar_ready = 1'b1;
        #1;
        if (ar_valid) total++;
        next_cycle();
        ar_ready = 1'b0;
        fence_i = 1'b1;
        #1;
        n_cmp++; if (r_ready !== 1'b1) begin n_err++; $display("FAIL fence_in_data: got r_ready=%b want 1", r_ready); end
        next_cycle();
        fence_i = 1'b0;
        r_valid = 1'b1; r_last = 1'b1; r_data = 64'hAAAA_0001_BBBB_0002;
        next_cycle();
        idle_bus();
        #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL fence_discard: got stall=%b want 1", fetch_stall); end
        serve(64'hAAAA_0001_BBBB_0002, 2'b00, 0, 0, stalls, hs);
        total += hs;
        n_cmp++; if (total !== 2 || ar_addr !== 32'h8000_0020) begin
            n_err++; $display("FAIL fence_rerequest: got hs=%0d addr=%h want 2/80000020", total, ar_addr);
        end
        n_cmp++; if (instF !== 32'hBBBB_0002) begin n_err++; $display("FAIL fence_instF: got %h want bbbb0002", instF); end
        next_cycle();
        fence_i = 1'b1;
        next_cycle();
        fence_i = 1'b0;
        #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL fence_idle: got stall=%b want 1", fetch_stall); end
        serve(64'hAAAA_0001_BBBB_0002, 2'b00, 0, 0, stalls, hs);
    endtask

    task automatic test_async_reset();
        pcF = 64'h0000_0000_8000_0030;
        idle_bus();
        next_cycle();
        ar_ready = 1'b1;
        next_cycle();
        ar_ready = 1'b0;
        #1;
        n_cmp++; if (r_ready !== 1'b1) begin n_err++; $display("FAIL areset_pre: got r_ready=%b want 1", r_ready); end
        #1;
        rst = 1'b0;
        pcEnable = 1'b0;
        #1;
        n_cmp++; if (r_ready !== 1'b0 || ar_valid !== 1'b0) begin
            n_err++; $display("FAIL areset_drop: got r_ready=%b ar_valid=%b want 0/0", r_ready, ar_valid);
        end
        next_cycle();
        rst = 1'b1;
        pcEnable = 1'b1;
        pcF = 64'h0000_0000_8000_0020;
        #1;
        n_cmp++; if (fetch_stall !== 1'b1 || instF !== 32'h0000_0013) begin
            n_err++; $display("FAIL areset_buf: got stall=%b inst=%h want 1/00000013", fetch_stall, instF);
        end
    endtask

    initial begin
        rst = 1'b0; pcF = '0; pcEnable = 1'b0; fence_i = 1'b0;
        idle_bus();
        test_reset();
        test_miss_hit();
        test_jump_addr();
        test_bus_error();
        test_fence_data();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
